// File: rtl/axi_llc_pkg.sv
// -----------------------------------------------------------------------------
// axi_llc_pkg
// Shared LLC definitions: static configuration record, data-way request and
// response payloads, requesting-unit indices and a block-offset helper.
// Macros: none.
// -----------------------------------------------------------------------------
package axi_llc_pkg;

    // Requesting unit indices into the way scheduler.
    localparam int unsigned EvictUnit  = 0;
    localparam int unsigned RefillUnit = 1;
    localparam int unsigned ReadUnit   = 2;
    localparam int unsigned WriteUnit  = 3;

    // Physical width of the block-offset field; the configured
    // BlockOffsetLength selects how many of its low bits are significant.
    localparam int unsigned BlockOffsetWidth = 4;

    typedef struct packed {
        logic [31:0] SetAssociativity;
        logic [31:0] NumLines;
        logic [31:0] NumBlocks;
        logic [31:0] BlockOffsetLength;
    } llc_cfg_t;

    typedef struct packed {
        logic                        we;
        logic [BlockOffsetWidth-1:0] blk_offset;
        logic [7:0]                  data;
    } way_inp_t;

    typedef struct packed {
        logic [7:0] data;
    } way_oup_t;

    // True when the significant offset bits (the low len bits) all equal
    // `ones`. With len = 0 every beat is both first and last of its line.
    function automatic logic blk_offset_is(input logic [BlockOffsetWidth-1:0] ofs,
                                           input logic [31:0]                 len,
                                           input logic                        ones);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < BlockOffsetWidth; i++) begin
            if ((i < len) && (ofs[i] != ones)) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// -----------------------------------------------------------------------------
// fifo_v3
// Synchronous FIFO with optional fall-through.
//   clk_i/rst_ni      clock, asynchronous active-low reset
//   flush_i           drop all contents
//   testmode_i        test-mode strap (no effect in this implementation)
//   full_o/empty_o    status flags, usage_o fill level (wraps when full)
//   data_i/push_i     write side, ignored while full
//   data_o/pop_i      read side, ignored while empty
// Macros: none.
// -----------------------------------------------------------------------------
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    dtype                  mem_q [DEPTH];
    logic                  stored_empty, push_eff, pop_eff, bypass;
    logic                  unused_tm;

    assign unused_tm    = testmode_i;
    assign stored_empty = (cnt_q == '0);
    assign full_o       = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o      = stored_empty & ~(FALL_THROUGH & push_i);
    assign usage_o      = cnt_q[ADDR_DEPTH-1:0];
    assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem_q[rd_ptr_q];

    assign push_eff = push_i & ~full_o;
    assign pop_eff  = pop_i & ~empty_o;
    // In fall-through mode a push popped in the same cycle never touches storage.
    assign bypass   = FALL_THROUGH & stored_empty & push_eff & pop_eff;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else if (!bypass) begin
            if (push_eff) begin
                wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + (ADDR_DEPTH+1)'(push_eff) - (ADDR_DEPTH+1)'(pop_eff);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff && !bypass && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_llc_way_sched.sv
// -----------------------------------------------------------------------------
// axi_llc_way_sched
// Round-robin scheduler sharing one data-way port among NumUnits requesters.
// Read requests record their unit index in an in-flight ID FIFO so that way
// responses are routed back in order; writes produce no response.
//   clk_i/rst_ni/test_i                     clock, async active-low reset, testmode
//   req_i/req_valid_i/req_ready_o           per-unit way requests
//   way_inp_o/way_inp_valid_o/_ready_i      shared data-way request
//   way_out_i/way_out_valid_i/_ready_o      shared data-way response
//   resp_o/resp_valid_o/resp_ready_i        per-unit responses
// Macros: AXI_LLC_WAY_SCHED_LOCK_EN -- when defined, a line burst (offset 0
// up to offset all-ones) keeps the grant on the issuing unit.
// -----------------------------------------------------------------------------
module axi_llc_way_sched #(
    parameter axi_llc_pkg::llc_cfg_t Cfg         = axi_llc_pkg::llc_cfg_t'('0),
    parameter int unsigned           NumUnits    = 4,
    parameter int unsigned           MaxInFlight = 2,
    parameter type                   way_inp_t   = axi_llc_pkg::way_inp_t,
    parameter type                   way_oup_t   = axi_llc_pkg::way_oup_t
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          test_i,
    input  way_inp_t [NumUnits-1:0]       req_i,
    input  logic     [NumUnits-1:0]       req_valid_i,
    output logic     [NumUnits-1:0]       req_ready_o,
    output way_inp_t                      way_inp_o,
    output logic                          way_inp_valid_o,
    input  logic                          way_inp_ready_i,
    input  way_oup_t                      way_out_i,
    input  logic                          way_out_valid_i,
    output logic                          way_out_ready_o,
    output way_oup_t [NumUnits-1:0]       resp_o,
    output logic     [NumUnits-1:0]       resp_valid_o,
    input  logic     [NumUnits-1:0]       resp_ready_i
);

    import axi_llc_pkg::*;

    localparam int unsigned IdW    = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned FifoAw = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;

    typedef logic [IdW-1:0] id_t;

    id_t                 prio_q, prio_d, gnt_q, gnt_d, gnt, head_id;
    logic                hold_q, hold_d;
    logic                found, grant_ok, inp_hs;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [NumUnits-1:0] eligible;
    logic [FifoAw-1:0]   unused_usage;
    logic                line_first, line_last;

    assign line_first = blk_offset_is(way_inp_o.blk_offset, Cfg.BlockOffsetLength, 1'b0);
    assign line_last  = blk_offset_is(way_inp_o.blk_offset, Cfg.BlockOffsetLength, 1'b1);

`ifdef AXI_LLC_WAY_SCHED_LOCK_EN
    logic lock_q, lock_d;
    id_t  lock_id_q, lock_id_d;
`else
    logic unused_line;
    assign unused_line = line_first ^ line_last;
`endif

    // Reads are masked out of arbitration while the ID FIFO is full, so a
    // stalled read never blocks a write from another unit.
    always_comb begin
        for (int unsigned i = 0; i < NumUnits; i++) begin
            eligible[i] = req_valid_i[i] & (req_i[i].we | ~fifo_full);
`ifdef AXI_LLC_WAY_SCHED_LOCK_EN
            if (lock_q && (id_t'(i) != lock_id_q)) begin
                eligible[i] = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt   = prio_q;
        found = 1'b0;
        if (hold_q) begin
            gnt   = gnt_q;
            found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NumUnits; k++) begin
                idx = (32'(prio_q) + k) % NumUnits;
                if (!found && eligible[idx]) begin
                    gnt   = id_t'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign grant_ok        = req_i[gnt].we | ~fifo_full;
    assign way_inp_o       = req_i[gnt];
    assign way_inp_valid_o = found & req_valid_i[gnt] & grant_ok;
    assign inp_hs          = way_inp_valid_o & way_inp_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (way_inp_valid_o) begin
            req_ready_o[gnt] = way_inp_ready_i;
        end
    end

    assign fifo_push = inp_hs & ~way_inp_o.we;
    assign hold_d    = way_inp_valid_o & ~way_inp_ready_i;
    assign gnt_d     = gnt;
    assign prio_d    = inp_hs ? id_t'((32'(gnt) + 32'd1) % NumUnits) : prio_q;

`ifdef AXI_LLC_WAY_SCHED_LOCK_EN
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (inp_hs) begin
            if (lock_q) begin
                if (line_last) begin
                    lock_d = 1'b0;
                end
            end else if (line_first && !line_last) begin
                lock_d    = 1'b1;
                lock_id_d = gnt;
            end
        end
    end
`endif

    // Response routing follows the ID at the FIFO head.
    assign way_out_ready_o = resp_ready_i[head_id] & ~fifo_empty;
    assign fifo_pop        = way_out_valid_i & way_out_ready_o;

    always_comb begin
        resp_valid_o = '0;
        for (int unsigned i = 0; i < NumUnits; i++) begin
            resp_o[i] = way_out_i;
        end
        if (!fifo_empty) begin
            resp_valid_o[head_id] = way_out_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= '0;
            gnt_q     <= '0;
            hold_q    <= 1'b0;
`ifdef AXI_LLC_WAY_SCHED_LOCK_EN
            lock_q    <= 1'b0;
            lock_id_q <= '0;
`endif
        end else begin
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
`ifdef AXI_LLC_WAY_SCHED_LOCK_EN
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxInFlight),
        .dtype        (id_t)
    ) i_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (test_i),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (unused_usage),
        .data_i     (gnt),
        .push_i     (fifo_push),
        .data_o     (head_id),
        .pop_i      (fifo_pop)
    );

`ifndef SYNTHESIS
    // A response with no outstanding read has no destination.
    a_resp_without_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(way_out_valid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_axi_llc_way_sched.sv
module tb_axi_llc_way_sched;

    localparam axi_llc_pkg::llc_cfg_t TbCfg = '{BlockOffsetLength: 32'd2, default: '0};

    logic                                clk, rst_n, test;
    axi_llc_pkg::way_inp_t [3:0]         req_i;
    logic                  [3:0]         req_valid, req_ready;
    axi_llc_pkg::way_inp_t               way_inp;
    logic                                way_inp_valid, way_inp_ready;
    axi_llc_pkg::way_oup_t               way_out;
    logic                                way_out_valid, way_out_ready;
    axi_llc_pkg::way_oup_t [3:0]         resp;
    logic                  [3:0]         resp_valid, resp_ready;
    logic                  [3:0]         blk [4];

    int n_cmp = 0;
    int n_bad = 0;

    axi_llc_way_sched #(
        .Cfg         (TbCfg),
        .NumUnits    (4),
        .MaxInFlight (2),
        .way_inp_t   (axi_llc_pkg::way_inp_t),
        .way_oup_t   (axi_llc_pkg::way_oup_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .test_i          (test),
        .req_i           (req_i),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .way_inp_o       (way_inp),
        .way_inp_valid_o (way_inp_valid),
        .way_inp_ready_i (way_inp_ready),
        .way_out_i       (way_out),
        .way_out_valid_i (way_out_valid),
        .way_out_ready_o (way_out_ready),
        .resp_o          (resp),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [3:0] w;
        logic       ir;
        logic       ov;
        logic [3:0] rr;
        logic [7:0] od;
        logic       iv;
        logic [1:0] g;
        logic [3:0] rq;
        logic       orr;
        logic [3:0] rv;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w, input logic ir,
                                input logic ov, input logic [3:0] rr, input logic [7:0] od,
                                input logic iv, input logic [1:0] g, input logic [3:0] rq,
                                input logic orr, input logic [3:0] rv);
        vec_t t;
        t.v = v; t.w = w; t.ir = ir; t.ov = ov; t.rr = rr; t.od = od;
        t.iv = iv; t.g = g; t.rq = rq; t.orr = orr; t.rv = rv;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic ir,
                         input logic ov, input logic [3:0] rr, input logic [7:0] od);
        for (int u = 0; u < 4; u++) begin
            req_i[u].we         = w[u];
            req_i[u].blk_offset = blk[u];
            req_i[u].data       = 8'h10 + 8'(u);
        end
        req_valid     = v;
        way_inp_ready = ir;
        way_out_valid = ov;
        resp_ready    = rr;
        way_out.data  = od;
    endtask

    task automatic check_outs(input string tag, input logic iv, input logic [1:0] g,
                              input logic [3:0] rq, input logic orr, input logic [3:0] rv);
        check({tag, ".inp_valid"}, 32'(way_inp_valid), 32'(iv));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(rq));
        check({tag, ".out_ready"}, 32'(way_out_ready), 32'(orr));
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'(rv));
        if (iv) check({tag, ".grant"}, 32'(way_inp.data), 32'(8'h10 + 8'(g)));
    endtask

    initial begin
        test  = 1'b0;
        rst_n = 1'b0;
        for (int u = 0; u < 4; u++) blk[u] = '0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);

        //        v     w     ir  ov  rr    od       iv  g     rq    or  rv
        tbl[0]  = mk(4'hF, 4'h0, 1, 0, 4'hF, 8'h00,  1, 2'd0, 4'h1, 0, 4'h0);
        tbl[1]  = mk(4'hF, 4'h0, 1, 1, 4'hF, 8'hA1,  1, 2'd1, 4'h2, 1, 4'h1);
        tbl[2]  = mk(4'hF, 4'h0, 1, 1, 4'hF, 8'hA2,  1, 2'd2, 4'h4, 1, 4'h2);
        tbl[3]  = mk(4'hF, 4'h0, 1, 1, 4'hF, 8'hA3,  1, 2'd3, 4'h8, 1, 4'h4);
        tbl[4]  = mk(4'hF, 4'h0, 1, 1, 4'hF, 8'hA4,  1, 2'd0, 4'h1, 1, 4'h8);
        tbl[5]  = mk(4'h0, 4'h0, 1, 1, 4'hF, 8'hA5,  0, 2'd0, 4'h0, 1, 4'h1);
        tbl[6]  = mk(4'h4, 4'h0, 0, 0, 4'hF, 8'h00,  1, 2'd2, 4'h0, 0, 4'h0);
        tbl[7]  = mk(4'h6, 4'h0, 0, 0, 4'hF, 8'h00,  1, 2'd2, 4'h0, 0, 4'h0);
        tbl[8]  = mk(4'h6, 4'h0, 0, 0, 4'hF, 8'h00,  1, 2'd2, 4'h0, 0, 4'h0);
        tbl[9]  = mk(4'h6, 4'h0, 1, 0, 4'hF, 8'h00,  1, 2'd2, 4'h4, 0, 4'h0);
        tbl[10] = mk(4'h0, 4'h0, 1, 1, 4'hF, 8'hB0,  0, 2'd0, 4'h0, 1, 4'h4);
        tbl[11] = mk(4'h2, 4'h0, 1, 0, 4'hF, 8'h00,  1, 2'd1, 4'h2, 0, 4'h0);
        tbl[12] = mk(4'h8, 4'h0, 1, 0, 4'hF, 8'h00,  1, 2'd3, 4'h8, 1, 4'h0);
        tbl[13] = mk(4'hB, 4'h1, 1, 0, 4'hF, 8'h00,  1, 2'd0, 4'h1, 1, 4'h0);
        tbl[14] = mk(4'hA, 4'h0, 1, 0, 4'hF, 8'h00,  0, 2'd0, 4'h0, 1, 4'h0);
        tbl[15] = mk(4'h2, 4'h0, 1, 1, 4'hD, 8'hB5,  0, 2'd0, 4'h0, 0, 4'h2);
        tbl[16] = mk(4'h2, 4'h0, 1, 1, 4'hD, 8'hB6,  0, 2'd0, 4'h0, 0, 4'h2);
        tbl[17] = mk(4'h2, 4'h0, 1, 1, 4'hF, 8'hB7,  0, 2'd0, 4'h0, 1, 4'h2);
        tbl[18] = mk(4'h2, 4'h0, 1, 1, 4'hF, 8'hB8,  1, 2'd1, 4'h2, 1, 4'h8);
        tbl[19] = mk(4'h0, 4'h0, 1, 1, 4'hF, 8'hB9,  0, 2'd0, 4'h0, 1, 4'h2);
        tbl[20] = mk(4'h0, 4'h0, 0, 0, 4'hF, 8'h00,  0, 2'd0, 4'h0, 0, 4'h0);

        // Reset state
        #1;
        check_outs("reset", 1'b0, 2'd0, 4'h0, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin, hold under back-pressure, full-FIFO stall, response routing
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].w, tbl[i].ir, tbl[i].ov, tbl[i].rr, tbl[i].od);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].iv, tbl[i].g, tbl[i].rq,
                       tbl[i].orr, tbl[i].rv);
            check($sformatf("vec%0d.resp_data", i),
                  {resp[3].data, resp[2].data, resp[1].data, resp[0].data},
                  {4{tbl[i].od}});
        end

        // Reset with two reads in flight (priority is at unit 2 here)
        @(negedge clk);
        drive(4'h4, 4'h0, 1'b1, 1'b0, 4'hF, 8'h00);
        #1 check_outs("rst_seq.rd2", 1'b1, 2'd2, 4'h4, 1'b0, 4'h0);
        @(negedge clk);
        drive(4'h1, 4'h0, 1'b1, 1'b0, 4'hF, 8'h00);
        #1 check_outs("rst_seq.rd0", 1'b1, 2'd0, 4'h1, 1'b1, 4'h0);
        @(negedge clk);
        drive(4'h2, 4'h0, 1'b1, 1'b0, 4'hF, 8'h00);
        #1 check_outs("rst_seq.full", 1'b0, 2'd0, 4'h0, 1'b1, 4'h0);
        #1;
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 8'hC0);
        #1 check_outs("rst_seq.in_reset", 1'b0, 2'd0, 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h3, 4'h0, 1'b1, 1'b0, 4'hF, 8'h00);
        #1 check_outs("rst_seq.prio0", 1'b1, 2'd0, 4'h1, 1'b0, 4'h0);
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 8'hC1);
        #1 check_outs("rst_seq.one_resp", 1'b0, 2'd0, 4'h0, 1'b1, 4'h1);
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 8'h00);
        #1 check_outs("rst_seq.drained", 1'b0, 2'd0, 4'h0, 1'b0, 4'h0);

`ifdef AXI_LLC_WAY_SCHED_LOCK_EN
        // Unit 0 line burst keeps the grant until its last beat
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) begin
            blk[0] = 4'(b);
            drive(4'h3, 4'h3, 1'b1, 1'b0, 4'hF, 8'h00);
            #1 check_outs($sformatf("lock.beat%0d", b), 1'b1, 2'd0, 4'h1, 1'b0, 4'h0);
            @(negedge clk);
        end
        drive(4'h3, 4'h3, 1'b1, 1'b0, 4'hF, 8'h00);
        #1 check_outs("lock.release", 1'b1, 2'd1, 4'h2, 1'b0, 4'h0);
`endif

        @(negedge clk);
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
